// File: rtl/trivium_pkg.sv
// Shared definitions for the Trivium keystream generator.
// Holds state/key/IV widths, the FSM state encodings and FIFO condition codes.
// No logic lives here; both the core and the top import it.
package trivium_pkg;

    localparam int STATE_W           = 288;
    localparam int KEY_W             = 80;
    localparam int IV_W              = 80;
    localparam int WARMUP_ROUNDS_DEF = 1152;

    // FIFO condition codes as reported by the downstream byte FIFO
    localparam logic [1:0] COND_EMPTY = 2'b00;
    localparam logic [1:0] COND_PART  = 2'b10;
    localparam logic [1:0] COND_FULL  = 2'b11;

    // FSM state encoding
    typedef logic [2:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE   = 3'd0;
    localparam fsm_state_t ST_LOAD   = 3'd1;
    localparam fsm_state_t ST_WARMUP = 3'd2;
    localparam fsm_state_t ST_RUN    = 3'd3;
    localparam fsm_state_t ST_FLUSH  = 3'd4;

endpackage

// File: rtl/trivium_core.sv
// Trivium 288-bit state register and round function; z is the keystream bit of the current state.
// Latency: z is combinational from the state; load/advance take effect on the next clk edge.
// Backpressure: advance=0 freezes the state, so the caller can stall without losing bits.
module trivium_core
    import trivium_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    output logic             z
);

    // s[i] holds Trivium bit s(i+1)
    logic [STATE_W-1:0] s;
    logic t1, t2, t3;
    logic t1_fb, t2_fb, t3_fb;

    // Output taps and nonlinear feedback of the three shift registers
    always_comb begin
        t1    = s[65]  ^ s[92];
        t2    = s[161] ^ s[176];
        t3    = s[242] ^ s[287];
        z     = t1 ^ t2 ^ t3;
        t1_fb = t1 ^ (s[90]  & s[91])  ^ s[170];
        t2_fb = t2 ^ (s[174] & s[175]) ^ s[263];
        t3_fb = t3 ^ (s[285] & s[286]) ^ s[68];
    end

    // Load key/IV layout, or shift all three registers by one round
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
        end else if (load) begin
            s <= {3'b111, 108'b0, 4'b0, iv, 13'b0, key};
        end else if (advance) begin
            s <= {s[286:177], t2_fb, s[175:93], t1_fb, s[91:0], t3_fb};
        end
    end

endmodule

// File: rtl/trivium_keystream.sv
// Trivium keystream generator: key/IV load, warm-up, then LSB-first bytes written into a FIFO.
// Latency: first fifo_write 1+WARMUP_ROUNDS+8+1 cycles after start is sampled, then one per 8 cycles.
// Backpressure: fifo_cond=FULL holds the pending byte; rounds freeze only when the next byte would complete.
module trivium_keystream
    import trivium_pkg::*;
#(
    parameter int WARMUP_ROUNDS = WARMUP_ROUNDS_DEF,
    parameter int LEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    input  logic [LEN_W-1:0] len,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       fifo_cond,
    output logic             fifo_write,
    output logic [7:0]       fifo_din,
    output logic             busy,
    output logic             done
);

    localparam int                WCNT_W    = $clog2(WARMUP_ROUNDS + 1);
    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_ROUNDS - 1);

    fsm_state_t        state;
    logic [WCNT_W-1:0] warm_cnt;
    logic [2:0]        bit_cnt;
    logic [6:0]        part;       // bits collected so far of the byte being built
    logic              pending;
    logic [7:0]        pend_byte;
    logic [LEN_W-1:0]  gen_left;   // bytes still to be generated
    logic [LEN_W-1:0]  rem;        // bytes still to be written to the FIFO
    logic              z;
    logic              load;
    logic              advance;
    logic              write_now;
    logic              stall;
    logic              abort_now;

    trivium_core u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .key     (key),
        .iv      (iv),
        .z       (z)
    );

    // Handshake and round-enable decisions for this cycle
    always_comb begin
        write_now = pending && (fifo_cond != COND_FULL);
        // A byte being written this edge frees the pending slot for the next one
        stall     = (bit_cnt == 3'd7) && pending && !write_now;
        load      = (state == ST_LOAD);
        advance   = (state == ST_WARMUP) || ((state == ST_RUN) && !stall);
        abort_now = abort && ((state == ST_LOAD) || (state == ST_WARMUP) || (state == ST_RUN));
    end

    assign busy = (state != ST_IDLE);

    // FSM, byte packer, pending register and FIFO write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            warm_cnt   <= '0;
            bit_cnt    <= '0;
            part       <= '0;
            pending    <= 1'b0;
            pend_byte  <= '0;
            gen_left   <= '0;
            rem        <= '0;
            fifo_write <= 1'b0;
            fifo_din   <= '0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            fifo_write <= write_now;
            fifo_din   <= write_now ? pend_byte : 8'h00;
            if (write_now) begin
                pending <= 1'b0;
                if (rem != '0) begin
                    rem <= rem - LEN_W'(1);
                end
            end

            if (abort_now) begin
                // A write issued on this same edge still goes out; everything else is dropped
                state   <= ST_IDLE;
                done    <= 1'b1;
                pending <= 1'b0;
                bit_cnt <= '0;
                part    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (len == '0) begin
                                done <= 1'b1;
                            end else begin
                                gen_left <= len;
                                rem      <= len;
                                state    <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        warm_cnt <= '0;
                        bit_cnt  <= '0;
                        part     <= '0;
                        state    <= ST_WARMUP;
                    end
                    ST_WARMUP: begin
                        if (warm_cnt == WARM_LAST) begin
                            state <= ST_RUN;
                        end else begin
                            warm_cnt <= warm_cnt + WCNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!stall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            part    <= {z, part[6:1]};
                            if (bit_cnt == 3'd7) begin
                                pending   <= 1'b1;
                                pend_byte <= {z, part};
                                gen_left  <= gen_left - LEN_W'(1);
                                if (gen_left == LEN_W'(1)) begin
                                    state <= ST_FLUSH;
                                end
                            end
                        end
                    end
                    ST_FLUSH: begin
                        if (rem == '0) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trivium_keystream.sv
// Randomized scoreboard bench for trivium_keystream against a bit-array Trivium model.
// Stimulus pushes expected bytes; an independent monitor pops and compares on every fifo_write.
// Uses a shortened warm-up so full runs stay short.
module tb_trivium_keystream;
    import trivium_pkg::*;

    localparam int W     = 64;
    localparam int LEN_W = 16;
    localparam int LAT   = 1 + W + 8 + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [KEY_W-1:0] key;
    logic [IV_W-1:0]  iv;
    logic [LEN_W-1:0] len;
    logic             start;
    logic             abort;
    logic [1:0]       fifo_cond;
    logic             fifo_write;
    logic [7:0]       fifo_din;
    logic             busy;
    logic             done;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [1:0] cond_at_edge = 2'b00;
    logic [7:0] exp_q[$];
    int         wr_cycles[$];
    int         wr_count   = 0;
    int         start_edge = 0;
    int         done_at    = 0;
    int         busy_bad   = 0;
    int         rel_edge   = 0;
    int         abort_edge = 0;
    logic [7:0] exp_b;
    logic [79:0] k;
    logic [79:0] v;

    trivium_keystream #(.WARMUP_ROUNDS(W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .iv         (iv),
        .len        (len),
        .start      (start),
        .abort      (abort),
        .fifo_cond  (fifo_cond),
        .fifo_write (fifo_write),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .done       (done)
    );

    initial forever #5 clk = ~clk;

    // Edge counter and the FIFO condition the DUT saw at that edge
    initial forever begin
        @(posedge clk);
        cyc++;
        cond_at_edge = fifo_cond;
    end

    // Monitor: every write is checked against the scoreboard head
    initial forever begin
        @(negedge clk);
        if (fifo_write === 1'b1) begin
            wr_count++;
            wr_cycles.push_back(cyc);
            checks++;
            if (cond_at_edge == COND_FULL) begin
                failures++;
                $display("FAIL write_while_full: fifo_write=1 with fifo_cond=%b, required no write", cond_at_edge);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got byte %02h, required no write", fifo_din);
            end else begin
                exp_b = exp_q.pop_front();
                if (fifo_din !== exp_b) begin
                    failures++;
                    $display("FAIL keystream_byte: got %02h, required %02h", fifo_din, exp_b);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference Trivium with 1-based bit numbering; pushes n keystream bytes after warm-up
    task automatic model_push(input logic [79:0] kk, input logic [79:0] vv, input int n);
        bit s [1:288];
        bit t1, t2, t3, zz;
        logic [7:0] b;
        b = 8'h00;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = kk[i-1];
            s[93 + i] = vv[i-1];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int r = 0; r < W + 8 * n; r++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            zz = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int i = 288; i > 178; i--) s[i] = s[i-1];
            s[178] = t2;
            for (int i = 177; i > 94; i--) s[i] = s[i-1];
            s[94] = t1;
            for (int i = 93; i > 1; i--) s[i] = s[i-1];
            s[1] = t3;
            if (r >= W) begin
                b[(r - W) % 8] = zz;
                if ((r - W) % 8 == 7) exp_q.push_back(b);
            end
        end
    endtask

    task automatic start_run(input logic [79:0] kk, input logic [79:0] vv, input int n, input bit with_model);
        tick();
        if (with_model) model_push(kk, vv, n);
        wr_cycles.delete();
        wr_count   = 0;
        key        = kk;
        iv         = vv;
        len        = LEN_W'(n);
        start      = 1'b1;
        start_edge = cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int i;
        i        = 0;
        done_at  = -1;
        busy_bad = 0;
        while (done_at < 0 && i < max_cyc) begin
            @(negedge clk);
            i++;
            if (done === 1'b1) done_at = cyc;
            else if (busy !== 1'b1) busy_bad++;
        end
        chk("done_within_budget", (done_at >= 0) ? 1 : 0, 1);
    endtask

    task automatic wait_writes(input int n, input int max_cyc);
        int i;
        i = 0;
        while (wr_count < n && i < max_cyc) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("writes_within_budget", (wr_count >= n) ? 1 : 0, 1);
    endtask

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        key = '0; iv = '0; len = '0; fifo_cond = COND_EMPTY;
        repeat (3) tick();
        chk("reset_fifo_write", fifo_write, 0);
        chk("reset_fifo_din", fifo_din, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;

        // Zero key/IV vector: write timing and done placement
        start_run(80'h0, 80'h0, 4, 1'b1);
        wait_done(LAT + 100);
        chk("vec_write_count", wr_count, 4);
        for (int i = 0; i < wr_cycles.size(); i++)
            chk("vec_write_cycle", wr_cycles[i] - start_edge, LAT + 8 * i);
        if (wr_cycles.size() > 0) chk("vec_done_after_last_write", done_at - wr_cycles[$], 1);
        chk("vec_busy_until_done", busy_bad, 0);
        chk("vec_busy_low_at_done", busy, 0);

        // Random key/IV pairs, FIFO either empty or partial
        for (int r = 0; r < 16; r++) begin
            k = rand80();
            v = rand80();
            fifo_cond = ($urandom_range(0, 1) == 1) ? COND_PART : COND_EMPTY;
            start_run(k, v, 32, 1'b1);
            wait_done(LAT + 8 * 32 + 100);
            chk("rand_write_count", wr_count, 32);
            chk("rand_busy_until_done", busy_bad, 0);
        end
        chk("rand_scoreboard_drained", exp_q.size(), 0);

        // Backpressure: FIFO full for 40 cycles mid-run
        fifo_cond = COND_EMPTY;
        k = rand80();
        v = rand80();
        start_run(k, v, 12, 1'b1);
        wait_writes(3, LAT + 100);
        fifo_cond = COND_FULL;
        repeat (40) @(negedge clk);
        #1;
        chk("bp_no_write_while_full", wr_count, 3);
        fifo_cond = COND_EMPTY;
        rel_edge  = cyc + 1;
        wait_done(8 * 12 + 100);
        chk("bp_write_count", wr_count, 12);
        if (wr_cycles.size() > 3) chk("bp_release_write_cycle", wr_cycles[3] - rel_edge, 0);

        // len = 0: immediate done, nothing written, never busy
        start_run(k, v, 0, 1'b0);
        wait_done(10);
        chk("len0_done_latency", done_at - start_edge, 0);
        chk("len0_busy_low", busy, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("len0_no_writes", wr_count, 0);

        // len = 1: exactly one byte
        start_run(k, v, 1, 1'b1);
        wait_done(LAT + 100);
        chk("len1_write_count", wr_count, 1);

        // Abort during warm-up, then rerun from byte 0
        k = rand80();
        v = rand80();
        start_run(k, v, 4, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        abort      = 1'b1;
        abort_edge = cyc + 1;
        tick();
        abort = 1'b0;
        wait_done(5);
        chk("abort_done_latency", done_at - abort_edge, 0);
        repeat (LAT + 40) @(negedge clk);
        #1;
        chk("abort_no_writes", wr_count, 0);
        chk("abort_busy_low", busy, 0);
        start_run(k, v, 4, 1'b1);
        wait_done(LAT + 100);
        chk("abort_rerun_count", wr_count, 4);

        // Reset during RUN after 3 bytes, then rerun from byte 0
        k = rand80();
        v = rand80();
        start_run(k, v, 10, 1'b1);
        wait_writes(3, LAT + 100);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("midrst_fifo_write", fifo_write, 0);
        chk("midrst_fifo_din", fifo_din, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        tick();
        rst = 1'b0;
        repeat (LAT + 100) @(negedge clk);
        #1;
        chk("midrst_no_more_writes", wr_count, 3);
        start_run(k, v, 4, 1'b1);
        wait_done(LAT + 100);
        chk("midrst_rerun_count", wr_count, 4);

        // start while busy with a different key is ignored
        k = rand80();
        v = rand80();
        start_run(k, v, 8, 1'b1);
        repeat (30) @(negedge clk);
        #1;
        key   = ~k;
        iv    = k;
        len   = LEN_W'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(LAT + 8 * 8 + 100);
        chk("ignored_start_write_count", wr_count, 8);

        repeat (5) tick();
        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
